// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard front end: synchronise/filter the lines, capture 11-bit frames,
// decode E0/F0 prefixes and queue key events. Optional: PS2_TYPEMATIC_SUPPRESS_EN.
module ps2_kb_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       arst_i,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_release,
  output logic       evt_extended,
  output logic       frame_err,
  output logic       ovf,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic          sclk, sdata;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_prev, sample;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // Filtered clock only follows after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (sclk == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= sclk;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign sample = filt_prev & ~filt_clk;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit, byte_vld, err_pulse;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      err_pulse <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (sample && !sdata) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (sample) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {sdata, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= sdata;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if ((^{shift, par_bit}) && sdata) byte_vld  <= 1'b1;
            else                              err_pulse <= 1'b1;
          end
        endcase
      end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= IDLE;
        err_pulse <= 1'b1;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  logic          ext_flag, rel_flag, suppress, push_req, pop, full, do_push;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_reg;

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  logic       last_vld, last_rel, last_ext;
  logic [7:0] last_code;

  // A held key repeats its make code; swallow repeats until its release is queued.
  assign suppress = !rel_flag && last_vld && !last_rel &&
                    (last_ext == ext_flag) && (last_code == shift);

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      last_vld  <= 1'b0;
      last_rel  <= 1'b0;
      last_ext  <= 1'b0;
      last_code <= '0;
    end else if (do_push) begin
      last_vld  <= 1'b1;
      last_rel  <= rel_flag;
      last_ext  <= ext_flag;
      last_code <= shift;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push_req  = byte_vld && (shift != 8'hE0) && (shift != 8'hF0) && !suppress;
  assign do_push   = push_req && (!full || pop);

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_reg  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ovf_reg <= push_req && full && !pop;
      if (err_pulse) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_vld) begin
        if (shift == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
      end
      if (do_push) begin
        mem[wr_ptr] <= {ext_flag, rel_flag, shift};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  assign {evt_extended, evt_release, evt_code} = mem[rd_ptr];
  assign frame_err = err_pulse;
  assign ovf       = ovf_reg;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_ps2_kb_controller.sv
// Scoreboard bench for ps2_kb_controller: expected events queued as frames are sent,
// compared as the consumer pops them.
module tb_ps2_kb_controller;
  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       arst_i = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b1;
  logic       evt_valid, evt_release, evt_extended, frame_err, ovf, busy;
  logic [7:0] evt_code;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_ovf = 0;
  int n_evt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  ps2_kb_controller #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .arst_i(arst_i), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_release(evt_release), .evt_extended(evt_extended),
    .frame_err(frame_err), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Monitor: count pulses and check every popped event against the scoreboard.
  always @(negedge clk) begin
    if (!arst_i) begin
      if (frame_err) n_err++;
      if (ovf) n_ovf++;
      if (evt_valid && evt_ready) begin
        n_evt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got ext=%0b rel=%0b code=%h, required none",
                   evt_extended, evt_release, evt_code);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({evt_extended, evt_release, evt_code} !== mon_exp) begin
            bad++;
            $display("FAIL event got ext=%0b rel=%0b code=%h, required ext=%0b rel=%0b code=%h",
                     evt_extended, evt_release, evt_code, mon_exp[9], mon_exp[8], mon_exp[7:0]);
          end else begin
            $display("event ext=%0b rel=%0b code=%h ok", evt_extended, evt_release, evt_code);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(15);
    ps2_clk = 1'b0;
    tick(30);
    ps2_clk = 1'b1;
    tick(15);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    $display("frame %h sent (bad_par=%0b)", b, bad_par);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 400) begin
      tick(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d evt_valid=%0b, required pending=0 evt_valid=0",
               name, exp_q.size(), evt_valid);
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if ({evt_valid, evt_release, evt_extended, frame_err, ovf, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got %b, required 000000",
               {evt_valid, evt_release, evt_extended, frame_err, ovf, busy});
    end
    total++;
    if (evt_code !== 8'h00) begin
      bad++;
      $display("FAIL reset_code got %h, required 00", evt_code);
    end
    arst_i = 1'b0;
    tick(20);
    total++;
    if (busy !== 1'b0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%0b valid=%0b, required 0 0", busy, evt_valid);
    end
  endtask

  task automatic test_make();
    int e0;
    e0 = n_err;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    wait_drain("make");
    total++;
    if (n_err !== e0) begin
      bad++;
      $display("FAIL make_frame_err got %0d, required %0d", n_err - e0, 0);
    end
  endtask

  task automatic test_break();
    exp_q.push_back({2'b01, 8'h1C});
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    wait_drain("break");
  endtask

  task automatic test_extended();
    exp_q.push_back({2'b11, 8'h75});
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h1C, 1'b0);
    wait_drain("extended");
  endtask

  task automatic test_parity_err();
    int e0, v0;
    e0 = n_err;
    v0 = n_evt;
    send_frame(8'h1C, 1'b1);
    tick(40);
    total++;
    if (n_err !== e0 + 1) begin
      bad++;
      $display("FAIL parity_err_pulses got %0d, required 1", n_err - e0);
    end
    total++;
    if (n_evt !== v0 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_no_event got events=%0d valid=%0b, required 0 0", n_evt - v0, evt_valid);
    end
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0);
    wait_drain("parity_recover");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_err;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy_mid got %0b, required 1", busy);
    end
    tick(TO + 20);
    total++;
    if (n_err !== e0 + 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort got err_pulses=%0d busy=%0b, required 1 0", n_err - e0, busy);
    end
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0);
    wait_drain("timeout_recover");
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    int o0;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    o0 = n_ovf;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, codes[i]});
      send_frame(codes[i], 1'b0);
    end
    tick(40);
    total++;
    if (n_ovf !== o0 + 1) begin
      bad++;
      $display("FAIL ovf_pulses got %0d, required 1", n_ovf - o0);
    end
    total++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h15) begin
      bad++;
      $display("FAIL ovf_head_held got valid=%0b code=%h, required 1 15", evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    wait_drain("ovf");
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_timeout();
    test_overflow();
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
